// File: rtl/ball_engine_pkg.sv
// Shared game-state encodings, court grid constants and direction types for
// the ball engine and the character location generators.
package ball_engine_pkg;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_GAME  = 3'd1,
        ST_P1WIN = 3'd2,
        ST_P2WIN = 3'd3,
        ST_TIE   = 3'd4,
        ST_PIONT = 3'd5
    } game_state_e;

    localparam int GRID_W       = 7;
    localparam int GRID_XMAX    = 63;
    localparam int GRID_MID_X   = 32;
    localparam int GRID_FLOOR_Y = 37;
    localparam int GRID_CH_W    = 3;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    typedef enum logic {
        SIDE_P1 = 1'b0,
        SIDE_P2 = 1'b1
    } side_e;

    typedef enum logic [1:0] {
        BE_IDLE,
        BE_SERVE,
        BE_FLY,
        BE_SCORED
    } ball_fsm_e;

    // One grid unit in the given direction; a negative step is +127 mod 128.
    function automatic logic [GRID_W-1:0] dir_add(input logic [GRID_W-1:0] pos,
                                                  input dir_e d);
        return pos + ((d == DIR_NEG) ? {GRID_W{1'b1}} : GRID_W'(1));
    endfunction

endpackage

// File: rtl/ball_engine_step_divider.sv
// Prescaler: one-cycle step pulse every DIV clocks, held at zero while clear.
module step_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic step
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign step = !clear && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || step) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ball_engine.sv
// Ball motion and scoring: flies the ball on the divided step tick, reflects it
// off walls, ceiling and character tops, and pulses a point on floor landings.
module ball_engine
    import ball_engine_pkg::*;
#(
    parameter int STEP_DIV  = 2,
    parameter int XMAX      = GRID_XMAX,
    parameter int FLOOR_Y   = GRID_FLOOR_Y,
    parameter int MID_X     = GRID_MID_X,
    parameter int CH_W      = GRID_CH_W,
    parameter int SERVE_GAP = 8,
    parameter int P1_SRV_X  = 16,
    parameter int P2_SRV_X  = 48,
    parameter int SRV_Y     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic [6:0] p1_x,
    input  logic [6:0] p1_y,
    input  logic [6:0] p2_x,
    input  logic [6:0] p2_y,
    output logic [6:0] ball_x,
    output logic [6:0] ball_y,
    output logic       p1_point,
    output logic       p2_point,
    output logic       in_play
);

    ball_fsm_e  fsm;
    side_e      server;
    dir_e       vx, vy, vx_n, vy_n;
    logic [7:0] gap_cnt;
    logic       step;
    logic [6:0] y_below, p1_right, p2_right, x_mv, y_mv;
    logic       hit_p1, hit_p2, floor_hit;

    step_divider #(.DIV(STEP_DIV)) u_step (
        .clk   (clk),
        .rst   (rst),
        .clear (fsm == BE_IDLE),
        .step  (step)
    );

    // Next position for a FLY step: paddle, then walls, then ceiling, then move.
    always_comb begin
        y_below   = ball_y + 7'd1;
        p1_right  = p1_x + 7'(CH_W - 1);
        p2_right  = p2_x + 7'(CH_W - 1);
        hit_p1    = (vy == DIR_POS) && (y_below == p1_y) &&
                    (ball_x >= p1_x) && (ball_x <= p1_right);
        hit_p2    = !hit_p1 && (vy == DIR_POS) && (y_below == p2_y) &&
                    (ball_x >= p2_x) && (ball_x <= p2_right);
        floor_hit = (vy == DIR_POS) && (y_below == 7'(FLOOR_Y)) && !hit_p1 && !hit_p2;

        vx_n = vx;
        vy_n = vy;
        if (hit_p1) begin
            vx_n = DIR_POS;
            vy_n = DIR_NEG;
        end else if (hit_p2) begin
            vx_n = DIR_NEG;
            vy_n = DIR_NEG;
        end
        if (ball_x == 7'd0) begin
            vx_n = DIR_POS;
        end else if (ball_x == 7'(XMAX)) begin
            vx_n = DIR_NEG;
        end
        if (ball_y == 7'd0) begin
            vy_n = DIR_POS;
        end
        x_mv = dir_add(ball_x, vx_n);
        y_mv = dir_add(ball_y, vy_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= BE_IDLE;
            server   <= SIDE_P1;
            vx       <= DIR_POS;
            vy       <= DIR_POS;
            gap_cnt  <= '0;
            ball_x   <= 7'(P1_SRV_X);
            ball_y   <= 7'(SRV_Y);
            p1_point <= 1'b0;
            p2_point <= 1'b0;
            in_play  <= 1'b0;
        end else begin
            p1_point <= 1'b0;
            p2_point <= 1'b0;
            if (state != ST_GAME) begin
                fsm     <= BE_IDLE;
                server  <= SIDE_P1;
                vx      <= DIR_POS;
                vy      <= DIR_POS;
                gap_cnt <= '0;
                ball_x  <= 7'(P1_SRV_X);
                ball_y  <= 7'(SRV_Y);
                in_play <= 1'b0;
            end else begin
                case (fsm)
                    BE_IDLE: begin
                        fsm <= BE_SERVE;
                    end
                    BE_SERVE: begin
                        ball_x  <= (server == SIDE_P2) ? 7'(P2_SRV_X) : 7'(P1_SRV_X);
                        ball_y  <= 7'(SRV_Y);
                        vx      <= (server == SIDE_P2) ? DIR_NEG : DIR_POS;
                        vy      <= DIR_POS;
                        fsm     <= BE_FLY;
                        in_play <= 1'b1;
                    end
                    BE_FLY: begin
                        if (step) begin
                            if (floor_hit) begin
                                ball_y  <= 7'(FLOOR_Y);
                                fsm     <= BE_SCORED;
                                gap_cnt <= '0;
                                in_play <= 1'b0;
                                if (ball_x < 7'(MID_X)) begin
                                    p2_point <= 1'b1;
                                    server   <= SIDE_P2;
                                end else begin
                                    p1_point <= 1'b1;
                                    server   <= SIDE_P1;
                                end
                            end else begin
                                ball_x <= x_mv;
                                ball_y <= y_mv;
                                vx     <= vx_n;
                                vy     <= vy_n;
                            end
                        end
                    end
                    BE_SCORED: begin
                        if (step) begin
                            if (gap_cnt == 8'(SERVE_GAP - 1)) begin
                                fsm <= BE_SERVE;
                            end else begin
                                gap_cnt <= gap_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        fsm <= BE_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: scripted rallies with hand-derived positions, then
// randomized paddles/state/reset against a behavioural game model.
module tb_ball_engine;

    localparam int STEP_DIV  = 2;
    localparam int XMAX      = 63;
    localparam int FLOOR_Y   = 37;
    localparam int MID_X     = 32;
    localparam int CH_W      = 3;
    localparam int SERVE_GAP = 8;
    localparam int P1_SRV_X  = 16;
    localparam int P2_SRV_X  = 48;
    localparam int SRV_Y     = 8;
    localparam int GAME      = 1;

    localparam int MD_IDLE = 0, MD_SERVE = 1, MD_FLY = 2, MD_SCORED = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state = 3'd0;
    logic [6:0] p1_x = 7'd0, p1_y = 7'd45, p2_x = 7'd60, p2_y = 7'd45;
    logic [6:0] ball_x, ball_y;
    logic       p1_point, p2_point, in_play;

    always #5 clk = ~clk;

    ball_engine dut (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .p1_x     (p1_x),
        .p1_y     (p1_y),
        .p2_x     (p2_x),
        .p2_y     (p2_y),
        .ball_x   (ball_x),
        .ball_y   (ball_y),
        .p1_point (p1_point),
        .p2_point (p2_point),
        .in_play  (in_play)
    );

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: game mode, ball position, +/-1 velocities, step phase.
    int m_mode, m_x, m_y, m_vx, m_vy, m_ticks, m_gap, m_p1, m_p2;
    bit m_srv2;

    task automatic model_reset();
        m_mode = MD_IDLE; m_x = P1_SRV_X; m_y = SRV_Y; m_vx = 1; m_vy = 1;
        m_ticks = 0; m_gap = 0; m_p1 = 0; m_p2 = 0; m_srv2 = 1'b0;
    endtask

    function automatic bit on_top(input int bx, input int by, input int px, input int py);
        return (by + 1 == py) && (bx >= px) && (bx <= px + CH_W - 1);
    endfunction

    task automatic model_fly_step();
        bit hit = 1'b0;
        if (m_vy == 1 && on_top(m_x, m_y, p1_x, p1_y)) begin
            hit = 1'b1; m_vx = 1; m_vy = -1;
        end else if (m_vy == 1 && on_top(m_x, m_y, p2_x, p2_y)) begin
            hit = 1'b1; m_vx = -1; m_vy = -1;
        end
        if (!hit && m_vy == 1 && m_y + 1 == FLOOR_Y) begin
            m_y = FLOOR_Y; m_mode = MD_SCORED; m_gap = 0;
            if (m_x < MID_X) begin m_p2 = 1; m_srv2 = 1'b1; end
            else begin m_p1 = 1; m_srv2 = 1'b0; end
        end else begin
            if (m_x == 0) m_vx = 1;
            else if (m_x == XMAX) m_vx = -1;
            if (m_y == 0) m_vy = 1;
            m_x += m_vx;
            m_y += m_vy;
        end
    endtask

    task automatic model_clock();
        bit stp = (m_mode != MD_IDLE) && ((m_ticks % STEP_DIV) == STEP_DIV - 1);
        m_ticks = (m_mode == MD_IDLE) ? 0 : m_ticks + 1;
        m_p1 = 0; m_p2 = 0;
        if (state != GAME) begin
            m_mode = MD_IDLE; m_x = P1_SRV_X; m_y = SRV_Y; m_vx = 1; m_vy = 1; m_srv2 = 1'b0;
        end else begin
            case (m_mode)
                MD_IDLE:  m_mode = MD_SERVE;
                MD_SERVE: begin
                    m_x = m_srv2 ? P2_SRV_X : P1_SRV_X; m_y = SRV_Y;
                    m_vx = m_srv2 ? -1 : 1; m_vy = 1; m_mode = MD_FLY;
                end
                MD_FLY:   if (stp) model_fly_step();
                default:  if (stp) begin
                    m_gap++;
                    if (m_gap == SERVE_GAP) m_mode = MD_SERVE;
                end
            endcase
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_clock();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_ball_x", ball_x, m_x);
            check("model_ball_y", ball_y, m_y);
            check("model_p1_point", p1_point, m_p1);
            check("model_p2_point", p2_point, m_p2);
            check("model_in_play", in_play, (m_mode == MD_FLY) ? 1 : 0);
        end
    end

    task automatic wait_pos(input string name, input int x, input int y, input int ep1, input int ep2);
        bit found = 1'b0;
        for (int n = 0; n < 600 && !found; n++) begin
            @(negedge clk);
            if (ball_x == x && ball_y == y) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s: ball at (%0d,%0d), required (%0d,%0d) within 600 cycles",
                     name, ball_x, ball_y, x, y);
        end else begin
            check({name, "_p1_point"}, p1_point, ep1);
            check({name, "_p2_point"}, p2_point, ep2);
        end
    endtask

    task automatic next_pos(input string name, input int x, input int y);
        int ox = ball_x;
        int oy = ball_y;
        bit moved = 1'b0;
        for (int n = 0; n < 40 && !moved; n++) begin
            @(negedge clk);
            if (ball_x != ox || ball_y != oy) moved = 1'b1;
        end
        if (!moved) begin
            total++; bad++;
            $display("FAIL %s: ball stuck at (%0d,%0d), required (%0d,%0d)", name, ox, oy, x, y);
        end else begin
            check({name, "_x"}, ball_x, x);
            check({name, "_y"}, ball_y, y);
        end
    endtask

    task automatic check_parked(input string name);
        check({name, "_x"}, ball_x, P1_SRV_X);
        check({name, "_y"}, ball_y, SRV_Y);
        check({name, "_in_play"}, in_play, 0);
        check({name, "_p1_point"}, p1_point, 0);
        check({name, "_p2_point"}, p2_point, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int frozen;
        int hold = 0;
        bit pulsed;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        check_parked("reset");

        state = 3'(GAME);
        @(negedge clk);
        check("serve_cycle_x", ball_x, 16);
        check("serve_cycle_in_play", in_play, 0);
        @(negedge clk);
        check("fly_start_in_play", in_play, 1);
        check("fly_start_y", ball_y, 8);
        @(negedge clk);
        check("first_step_x", ball_x, 17);
        check("first_step_y", ball_y, 9);

        // Unobstructed diagonal from (16,8) lands at (44,37) on the P2 half.
        wait_pos("p1_land", 44, 37, 1, 0);
        frozen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) check("p1_pulse_len", p1_point, 0);
            if (ball_x == 44 && ball_y == 37) frozen++;
            else break;
        end
        check("scored_frozen_cycles", frozen, 2 * SERVE_GAP);
        check("reserve_p1_x", ball_x, 16);
        check("reserve_p1_y", ball_y, 8);
        next_pos("reserve_p1_step", 17, 9);

        p1_x = 7'd20; p1_y = 7'd13;
        wait_pos("before_p1_hit", 20, 12, 0, 0);
        next_pos("p1_bounce", 21, 11);
        wait_pos("right_wall", 63, 31, 0, 0);
        next_pos("right_bounce", 62, 32);
        p1_x = 7'd0; p1_y = 7'd45;
        wait_pos("p1_land2", 58, 37, 1, 0);

        p2_x = 7'd22; p2_y = 7'd15;
        wait_pos("serve3", 16, 8, 0, 0);
        wait_pos("before_p2_hit", 22, 14, 0, 0);
        next_pos("p2_bounce", 21, 13);
        wait_pos("left_wall", 0, 8, 0, 0);
        next_pos("left_bounce", 1, 9);
        wait_pos("p2_land", 28, 37, 0, 1);
        p2_x = 7'd60; p2_y = 7'd45;
        wait_pos("p2_serve", 48, 8, 0, 0);
        next_pos("p2_serve_step", 47, 9);

        repeat (5) @(negedge clk);
        state = 3'd0;
        @(negedge clk);
        check_parked("menu_abort");
        state = 3'(GAME);

        pulsed = 1'b0;
        for (int n = 0; n < 600 && !pulsed; n++) begin
            @(negedge clk);
            if (p1_point || p2_point) pulsed = 1'b1;
        end
        check("scored_reached", pulsed, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_parked("async_rst");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) begin
                p1_x = 7'($urandom_range(0, 63)); p1_y = 7'($urandom_range(5, 40));
            end
            if ($urandom_range(0, 29) == 0) begin
                p2_x = 7'($urandom_range(0, 63)); p2_y = 7'($urandom_range(5, 40));
            end
            if (state != 3'(GAME)) begin
                if (hold == 0) state = 3'(GAME);
                else hold--;
            end else if ($urandom_range(0, 999) == 0) begin
                int v = $urandom_range(0, 4);
                state = (v == 0) ? 3'd0 : 3'(v + 1);
                hold = $urandom_range(0, 6);
            end
            if ($urandom_range(0, 2999) == 0) begin
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
